cpu_mem_responder: RTL and testbench

Environment-side responder for the processor-under-test bus (clk, reset, PC, instruction, WE, address_to_mem, data_to_mem, data_from_mem). It sits opposite the CPU wrapper and plays the memory system. It serves instruction fetches from a loadable instruction RAM and services data reads and writes from a data RAM. It also sequences the CPU reset, detects program completion or timeout, and publishes a write trace for the scoreboard.

---
 rtl/cpu_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the processor-under-test bus: instruction/data RAMs,
// CPU reset sequencing, halt/timeout detection and a registered write trace.
module cpu_mem_responder #(
    parameter int          IMEM_WORDS   = 64,
    parameter int          DMEM_WORDS   = 128,
    parameter int          RESET_CYCLES = 4,
    parameter int          TIMEOUT      = 1024,
    parameter logic [31:0] HALT_INSTR   = 32'h0000006F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_en,
    input  logic        load_sel,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        addr_err,
    output logic [31:0] cycle_count,
    output logic        cpu_reset,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    input  logic        we,
    input  logic [31:0] addr_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic        wr_valid,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data
);
    localparam int IW  = $clog2(IMEM_WORDS);
    localparam int DW  = $clog2(DMEM_WORDS);
    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST     = RCW'(RESET_CYCLES - 1);
    localparam logic [31:0]    TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t state_reg, state_next;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [RCW-1:0] rst_cnt_reg;
    logic [31:0]    cycle_count_reg;
    logic [31:0]    pc_prev_reg;
    logic           halt_seen_reg;
    logic           addr_err_reg;
    logic           wr_valid_reg;
    logic [31:0]    wr_addr_reg;
    logic [31:0]    wr_data_reg;

    // Upper address bits beyond the RAM window must be zero for a hit.
    logic          imem_hit, dmem_hit, load_hit_i, load_hit_d;
    logic [IW-1:0] imem_idx, load_idx_i;
    logic [DW-1:0] dmem_idx, load_idx_d;
    logic          in_run, load_ok, cpu_wr, cpu_err, halt_cond, entering_reset;
    logic          unused_bits;

    assign imem_hit   = (pc[31:IW+2] == '0);
    assign imem_idx   = pc[IW+1:2];
    assign dmem_hit   = (addr_to_mem[31:DW+2] == '0);
    assign dmem_idx   = addr_to_mem[DW+1:2];
    assign load_hit_i = (load_addr[31:IW+2] == '0);
    assign load_idx_i = load_addr[IW+1:2];
    assign load_hit_d = (load_addr[31:DW+2] == '0);
    assign load_idx_d = load_addr[DW+1:2];
    assign unused_bits = &{1'b0, pc[1:0], addr_to_mem[1:0], load_addr[1:0]};

    assign in_run    = (state_reg == ST_RUN);
    assign load_ok   = (state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                       (state_reg == ST_TIMEOUT);
    assign cpu_wr    = in_run && we && dmem_hit;
    assign cpu_err   = in_run && !dmem_hit;
    assign halt_cond = in_run && (instruction == HALT_INSTR) && (pc == pc_prev_reg);
    assign entering_reset = (state_next == ST_RESET) && (state_reg != ST_RESET);

    assign instruction   = imem_hit ? imem[imem_idx] : 32'h0;
    assign data_from_mem = dmem_hit ? dmem[dmem_idx] : 32'h0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_RESET;
            ST_RESET:   if (rst_cnt_reg == RST_LAST) state_next = ST_RUN;
            ST_RUN: begin
                // Halt takes priority when it lands on the final allowed cycle.
                if (halt_cond && halt_seen_reg)
                    state_next = ST_DONE;
                else if (cycle_count_reg >= TIMEOUT_LAST)
                    state_next = ST_TIMEOUT;
            end
            ST_DONE,
            ST_TIMEOUT: if (start) state_next = ST_RESET;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            rst_cnt_reg     <= '0;
            cycle_count_reg <= '0;
            pc_prev_reg     <= '0;
            halt_seen_reg   <= 1'b0;
            addr_err_reg    <= 1'b0;
            wr_valid_reg    <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            pc_prev_reg   <= pc;
            halt_seen_reg <= halt_cond;
            wr_valid_reg  <= cpu_wr;
            if (cpu_wr) begin
                wr_addr_reg <= addr_to_mem;
                wr_data_reg <= data_to_mem;
            end
            if (entering_reset) begin
                rst_cnt_reg     <= '0;
                cycle_count_reg <= '0;
                addr_err_reg    <= 1'b0;
            end else begin
                if (state_reg == ST_RESET)
                    rst_cnt_reg <= rst_cnt_reg + 1'b1;
                if (in_run && (cycle_count_reg != 32'hFFFF_FFFF))
                    cycle_count_reg <= cycle_count_reg + 32'd1;
                if (cpu_err)
                    addr_err_reg <= 1'b1;
            end
        end
    end

    // RAM contents deliberately survive reset_n so a run can be repeated.
    always_ff @(posedge clk) begin
        if (load_en && load_ok && !load_sel && load_hit_i)
            imem[load_idx_i] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (cpu_wr)
            dmem[dmem_idx] <= data_to_mem;
        else if (load_en && load_ok && load_sel && load_hit_d)
            dmem[load_idx_d] <= load_data;
    end

    assign busy        = (state_reg == ST_RESET) || in_run;
    assign done        = (state_reg == ST_DONE);
    assign timeout     = (state_reg == ST_TIMEOUT);
    assign cpu_reset   = !in_run;
    assign addr_err    = addr_err_reg;
    assign cycle_count = cycle_count_reg;
    assign wr_valid    = wr_valid_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: table-driven preload/fetch vectors plus
// hand-written run sequences (halt, writes, errors, mid-run reset, timeout).
module tb_cpu_mem_responder;
    localparam logic [31:0] HALT = 32'h0000006F;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_en = 1'b0, load_sel = 1'b0, start = 1'b0, we = 1'b0;
    logic [31:0] load_addr = '0, load_data = '0;
    logic [31:0] pc = '0, addr_to_mem = '0, data_to_mem = '0;
    logic        busy, done, timeout, addr_err, cpu_reset, wr_valid;
    logic [31:0] cycle_count, instruction, data_from_mem, wr_addr, wr_data;

    int n_checks = 0;
    int n_err    = 0;

    cpu_mem_responder dut (
        .clk(clk), .reset_n(reset_n),
        .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
        .start(start), .busy(busy), .done(done), .timeout(timeout), .addr_err(addr_err),
        .cycle_count(cycle_count), .cpu_reset(cpu_reset),
        .pc(pc), .instruction(instruction),
        .we(we), .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem),
        .data_from_mem(data_from_mem),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] data;
    } load_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts RESET cycles from the current negedge until the DUT enters RUN.
    task automatic wait_run(output int rcyc);
        rcyc = 0;
        for (int i = 0; i < 20 && cpu_reset; i++) begin
            if (busy) rcyc++;
            @(negedge clk);
        end
        check_bit("run_entry", cpu_reset, 1'b0);
    endtask

    // PC trace 0 -> 4 -> 4 -> 4 against imem[1] = HALT.
    task automatic run_halt(input string tag);
        pc = 32'h0;
        @(negedge clk);
        pc = 32'h4;
        @(negedge clk);
        @(negedge clk);
        check_bit({tag, "_not_done_early"}, done, 1'b0);
        @(negedge clk);
        check_bit({tag, "_done"}, done, 1'b1);
        check_word({tag, "_cycles"}, cycle_count, 32'd4);
        check_bit({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        $display("run %s: done=%b cycle_count=%0d", tag, done, cycle_count);
        pc = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_t loads[9];
        vec_t  vecs[6];
        int    rc;
        int    exp_cnt;
        int    run_cycles;

        loads[0] = '{1'b0, 32'h000, 32'h00000013};
        loads[1] = '{1'b0, 32'h004, HALT};
        loads[2] = '{1'b0, 32'h0FC, 32'hA5A50063};
        loads[3] = '{1'b0, 32'h100, 32'hBAD0BAD0};
        loads[4] = '{1'b1, 32'h000, 32'h11111111};
        loads[5] = '{1'b1, 32'h010, 32'h44444444};
        loads[6] = '{1'b1, 32'h1FC, 32'h7F7F7F7F};
        loads[7] = '{1'b1, 32'h200, 32'hBAD1BAD1};
        loads[8] = '{1'b1, 32'h014, 32'h00000000};

        vecs[0] = '{"base",     32'h000,      32'h000,      32'h00000013, 32'h11111111};
        vecs[1] = '{"word1",    32'h004,      32'h010,      HALT,         32'h44444444};
        vecs[2] = '{"lowbits",  32'h007,      32'h013,      HALT,         32'h44444444};
        vecs[3] = '{"topword",  32'h0FC,      32'h1FC,      32'hA5A50063, 32'h7F7F7F7F};
        vecs[4] = '{"justout",  32'h100,      32'h200,      32'h0,        32'h0};
        vecs[5] = '{"farout",   32'h80000000, 32'hFFFFFFFC, 32'h0,        32'h0};

        // Reset values while reset_n is held low
        repeat (2) @(negedge clk);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_timeout", timeout, 1'b0);
        check_bit("rst_addr_err", addr_err, 1'b0);
        check_bit("rst_cpu_reset", cpu_reset, 1'b1);
        check_bit("rst_wr_valid", wr_valid, 1'b0);
        check_word("rst_cycle_count", cycle_count, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Preload in IDLE; out-of-range words must not alias onto index 0
        for (int i = 0; i < 9; i++) begin
            load_en = 1'b1; load_sel = loads[i].sel;
            load_addr = loads[i].addr; load_data = loads[i].data;
            @(negedge clk);
            $display("load sel=%0d addr=%h data=%h", loads[i].sel, loads[i].addr, loads[i].data);
        end
        load_en = 1'b0;

        for (int i = 0; i < 6; i++) begin
            pc = vecs[i].pc; addr_to_mem = vecs[i].addr;
            #1;
            check_word({vecs[i].name, "_instr"}, instruction, vecs[i].exp_instr);
            check_word({vecs[i].name, "_rdata"}, data_from_mem, vecs[i].exp_data);
            $display("vec %s pc=%h addr=%h instr=%h rdata=%h",
                     vecs[i].name, pc, addr_to_mem, instruction, data_from_mem);
            @(negedge clk);
        end

        // Run 1: reset sequencing and halt detection
        pc = 32'h0; addr_to_mem = 32'h0;
        pulse_start();
        wait_run(rc);
        check_word("run1_reset_len", 32'(rc), 32'd4);
        check_word("run1_first_instr", instruction, 32'h00000013);
        run_halt("run1");

        // Run 2 (restart from DONE): writes, error flag, ignored load/start
        pulse_start();
        wait_run(rc);
        check_word("run2_reset_len", 32'(rc), 32'd4);
        exp_cnt = 0;
        check_word("run2_count_clear", cycle_count, 32'(exp_cnt));
        we = 1'b1; addr_to_mem = 32'h10; data_to_mem = 32'hDEADBEEF;
        #1 check_word("wr_old_data", data_from_mem, 32'h44444444);
        @(negedge clk); exp_cnt++;
        check_bit("wr_valid_pulse", wr_valid, 1'b1);
        check_word("wr_addr", wr_addr, 32'h10);
        check_word("wr_data", wr_data, 32'hDEADBEEF);
        we = 1'b0;
        #1 check_word("wr_readback", data_from_mem, 32'hDEADBEEF);
        $display("write addr=%h data=%h wr_valid=%b", wr_addr, wr_data, wr_valid);
        @(negedge clk); exp_cnt++;
        check_bit("wr_valid_single", wr_valid, 1'b0);
        check_bit("addr_err_clean", addr_err, 1'b0);

        we = 1'b1; addr_to_mem = 32'h200; data_to_mem = 32'h12345678;
        #1 check_word("oor_rdata", data_from_mem, 32'h0);
        @(negedge clk); exp_cnt++;
        check_bit("oor_no_wr_valid", wr_valid, 1'b0);
        check_bit("oor_addr_err", addr_err, 1'b1);
        we = 1'b0; addr_to_mem = 32'h0;
        #1 check_word("oor_no_alias", data_from_mem, 32'h11111111);
        $display("oor write addr=200 addr_err=%b", addr_err);

        load_en = 1'b1; load_sel = 1'b1; load_addr = 32'h10; load_data = 32'hCAFEF00D;
        start = 1'b1;
        @(negedge clk); exp_cnt++;
        load_en = 1'b0; start = 1'b0; addr_to_mem = 32'h10;
        #1 check_word("run_load_ignored", data_from_mem, 32'hDEADBEEF);
        check_bit("run_start_ignored", cpu_reset, 1'b0);
        check_word("run2_count_a", cycle_count, 32'(exp_cnt));
        @(negedge clk); exp_cnt++;
        check_word("run2_count_b", cycle_count, 32'(exp_cnt));
        check_bit("run2_still_busy", busy, 1'b1);

        // Asynchronous reset mid-run
        reset_n = 1'b0;
        #1;
        check_bit("mid_busy", busy, 1'b0);
        check_bit("mid_cpu_reset", cpu_reset, 1'b1);
        check_bit("mid_addr_err", addr_err, 1'b0);
        check_bit("mid_wr_valid", wr_valid, 1'b0);
        check_word("mid_cycle_count", cycle_count, 32'h0);
        check_word("mid_wr_addr", wr_addr, 32'h0);
        check_word("mid_wr_data", wr_data, 32'h0);
        $display("mid-run reset: busy=%b cpu_reset=%b", busy, cpu_reset);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_word("mid_dmem_kept", data_from_mem, 32'hDEADBEEF);
        @(negedge clk);

        // Run 3: never halts; first cycle does an out-of-range read
        pc = 32'h0; we = 1'b0; addr_to_mem = 32'h400;
        pulse_start();
        wait_run(rc);
        check_word("run3_reset_len", 32'(rc), 32'd4);
        check_bit("run3_err_not_in_reset", addr_err, 1'b0);
        run_cycles = 0;
        for (int i = 0; i < 1100 && !cpu_reset; i++) begin
            run_cycles++;
            @(negedge clk);
            if (run_cycles == 1) begin
                check_bit("oor_read_err", addr_err, 1'b1);
                addr_to_mem = 32'h10;
            end
        end
        check_word("timeout_run_len", 32'(run_cycles), 32'd1024);
        check_bit("timeout_flag", timeout, 1'b1);
        check_bit("timeout_done", done, 1'b0);
        check_bit("timeout_cpu_reset", cpu_reset, 1'b1);
        check_word("timeout_count", cycle_count, 32'd1024);
        check_bit("timeout_err_sticky", addr_err, 1'b1);
        $display("timeout: run_cycles=%0d cycle_count=%0d", run_cycles, cycle_count);

        // Preload accepted in TIMEOUT
        load_en = 1'b1; load_sel = 1'b1; load_addr = 32'h14; load_data = 32'h55AA55AA;
        @(negedge clk);
        load_en = 1'b0; addr_to_mem = 32'h14;
        #1 check_word("timeout_load", data_from_mem, 32'h55AA55AA);

        // Run 4 (restart from TIMEOUT): flags clear, preload ignored in RESET
        pulse_start();
        check_bit("run4_err_cleared", addr_err, 1'b0);
        check_word("run4_count_cleared", cycle_count, 32'h0);
        load_en = 1'b1; load_sel = 1'b1; load_addr = 32'h14; load_data = 32'hFFFF0000;
        wait_run(rc);
        load_en = 1'b0;
        check_word("run4_reset_len", 32'(rc), 32'd4);
        #1 check_word("reset_load_ignored", data_from_mem, 32'h55AA55AA);
        run_halt("run4");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
